// File: rtl/fencing_action_fsm.sv
// Per-player fencing action/scoring FSM.
// Tracks this player's action (idle/block/lunge) from IR gestures, evaluates a
// sword-tip hit against the opponent's body box once per syncer frame, and
// publishes packed player/opponent records with a one-cycle valid strobe.
//
// Handshake: ir_in_valid and syncer_in_valid are single-cycle strobes with no
// back-pressure; data_out_valid is a single-cycle strobe raised exactly two
// cycles after an accepted syncer_in_valid. All outputs hold their value
// between strobes, except player_scored_out which drops the cycle after.
module fencing_action_fsm #(
  parameter int LUNGE_FRAMES = 30,
  parameter int SCORE_MAX    = 7
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  input  logic        block_in,
  input  logic        lunge_in,
  input  logic        ir_in_valid,
  input  logic [62:0] player_location_in,
  input  logic [88:0] opponent_data_in,
  input  logic        opponent_scored_in,
  input  logic        syncer_in_valid,
  output logic [88:0] player_data_out,
  output logic        player_scored_out,
  output logic [88:0] opponent_data_out,
  output logic        data_out_valid
);

  localparam int            CW   = $clog2(LUNGE_FRAMES + 1);
  localparam logic [CW-1:0] LF   = CW'(LUNGE_FRAMES);
  localparam logic [2:0]    SMAX = 3'(SCORE_MAX);

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'b00,
    ACT_BLOCK = 2'b01,
    ACT_LUNGE = 2'b10
  } act_e;

  typedef enum logic [1:0] {
    S_WAIT = 2'b00,
    S_EVAL = 2'b01,
    S_EMIT = 2'b10
  } state_e;

  state_e        state_q;
  act_e          action_q, action_d;
  act_e          eval_act_q;        // action as it was when the frame arrived
  logic [CW-1:0] cnt_q, cnt_d;
  logic          latch_q, latch_d;  // one hit per lunge
  logic [2:0]    score_q, score_d;
  logic [10:0]   anchor_x_q, anchor_x_d;
  logic [9:0]    anchor_y_q, anchor_y_d;
  logic [62:0]   loc_q;
  logic [88:0]   opp_q;
  logic          opp_sc_q;

  // Captured geometry: own tip and opponent's body box corners.
  logic [10:0] tip_x, oax, obx, x_lo, x_hi;
  logic [9:0]  tip_y, oay, oby, y_lo, y_hi;
  logic [1:0]  opp_act;
  logic        in_box, hit;
  act_e        ir_act;

  assign tip_x   = loc_q[62:52];
  assign tip_y   = loc_q[51:42];
  assign oax     = opp_q[64:54];
  assign oay     = opp_q[53:44];
  assign obx     = opp_q[43:33];
  assign oby     = opp_q[32:23];
  assign opp_act = opp_q[22:21];
  assign x_lo    = (oax < obx) ? oax : obx;
  assign x_hi    = (oax < obx) ? obx : oax;
  assign y_lo    = (oay < oby) ? oay : oby;
  assign y_hi    = (oay < oby) ? oby : oay;
  assign in_box  = (tip_x >= x_lo) && (tip_x <= x_hi) && (tip_y >= y_lo) && (tip_y <= y_hi);
  assign ir_act  = block_in ? ACT_BLOCK : (lunge_in ? ACT_LUNGE : ACT_IDLE);

  // Next action/score/lunge bookkeeping: frame evaluation first, IR update last.
  always_comb begin
    hit        = 1'b0;
    action_d   = action_q;
    cnt_d      = cnt_q;
    latch_d    = latch_q;
    score_d    = score_q;
    anchor_x_d = anchor_x_q;
    anchor_y_d = anchor_y_q;
    if (state_q == S_EVAL) begin
      hit = (eval_act_q == ACT_LUNGE) && !latch_q && (opp_act != ACT_BLOCK) &&
            !opp_sc_q && in_box;
      if (hit) begin
        score_d = (score_q == SMAX) ? score_q : score_q + 3'd1;
        latch_d = 1'b1;
      end
      if (eval_act_q == ACT_LUNGE) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == LF) action_d = ACT_IDLE;
      end
      // Simultaneous hits go to the opponent.
      if (opp_sc_q) action_d = ACT_IDLE;
    end
    if (ir_in_valid) begin
      if ((ir_act == ACT_LUNGE) && (action_q != ACT_LUNGE)) begin
        cnt_d      = '0;
        latch_d    = 1'b0;
        anchor_x_d = tip_x;
        anchor_y_d = tip_y;
      end
      action_d = ir_act;
    end
  end

  // Frame FSM with registered outputs; reset cancels any in-flight frame.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      state_q           <= S_WAIT;
      action_q          <= ACT_IDLE;
      eval_act_q        <= ACT_IDLE;
      cnt_q             <= '0;
      latch_q           <= 1'b0;
      score_q           <= '0;
      anchor_x_q        <= '0;
      anchor_y_q        <= '0;
      loc_q             <= '0;
      opp_q             <= '0;
      opp_sc_q          <= 1'b0;
      player_data_out   <= '0;
      player_scored_out <= 1'b0;
      opponent_data_out <= '0;
      data_out_valid    <= 1'b0;
    end else begin
      action_q   <= action_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      score_q    <= score_d;
      anchor_x_q <= anchor_x_d;
      anchor_y_q <= anchor_y_d;
      case (state_q)
        S_WAIT: begin
          loc_q          <= player_location_in;
          opp_q          <= opponent_data_in;
          opp_sc_q       <= opponent_scored_in;
          data_out_valid <= 1'b0;
          if (syncer_in_valid) begin
            eval_act_q <= action_q;
            state_q    <= S_EVAL;
          end
        end
        S_EVAL: begin
          player_data_out   <= {score_d, loc_q, action_d, anchor_x_d, anchor_y_d};
          opponent_data_out <= opp_q;
          player_scored_out <= hit;
          data_out_valid    <= 1'b1;
          state_q           <= S_EMIT;
        end
        S_EMIT: begin
          data_out_valid    <= 1'b0;
          player_scored_out <= 1'b0;
          state_q           <= S_WAIT;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fencing_action_fsm.sv
// Directed bench for fencing_action_fsm: hand-computed records per frame.
module tb_fencing_action_fsm;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        block_in = 1'b0;
  logic        lunge_in = 1'b0;
  logic        ir_in_valid = 1'b0;
  logic [62:0] player_location_in = '0;
  logic [88:0] opponent_data_in = '0;
  logic        opponent_scored_in = 1'b0;
  logic        syncer_in_valid = 1'b0;
  logic [88:0] player_data_out;
  logic        player_scored_out;
  logic [88:0] opponent_data_out;
  logic        data_out_valid;

  int checks = 0;
  int failures = 0;

  fencing_action_fsm dut (
    .clk_pixel_in       (clk),
    .rst_in             (rst_in),
    .block_in           (block_in),
    .lunge_in           (lunge_in),
    .ir_in_valid        (ir_in_valid),
    .player_location_in (player_location_in),
    .opponent_data_in   (opponent_data_in),
    .opponent_scored_in (opponent_scored_in),
    .syncer_in_valid    (syncer_in_valid),
    .player_data_out    (player_data_out),
    .player_scored_out  (player_scored_out),
    .opponent_data_out  (opponent_data_out),
    .data_out_valid     (data_out_valid)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [62:0] mk_loc(input int tx, input int ty, input int ax,
                                         input int ay, input int bx, input int by);
    return {tx[10:0], ty[9:0], ax[10:0], ay[9:0], bx[10:0], by[9:0]};
  endfunction

  function automatic logic [88:0] mk_data(input int sc, input logic [62:0] loc,
                                          input int act, input int anx, input int any_);
    return {sc[2:0], loc, act[1:0], anx[10:0], any_[9:0]};
  endfunction

  task automatic chk(input string tag, input logic [88:0] obs, input logic [88:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic ir_pulse(input logic b, input logic l);
    @(negedge clk);
    ir_in_valid = 1'b1; block_in = b; lunge_in = l;
    @(negedge clk);
    ir_in_valid = 1'b0; block_in = 1'b0; lunge_in = 1'b0;
  endtask

  task automatic set_loc(input logic [62:0] loc);
    @(negedge clk);
    player_location_in = loc;
    @(negedge clk);
  endtask

  // One frame: strobe sync (optionally with an IR lunge), check the emitted record.
  task automatic sync_chk(input string tag, input logic [62:0] loc, input logic [88:0] opp,
                          input logic osc, input logic ir_l, input logic exp_sc,
                          input logic [88:0] exp_pd);
    @(negedge clk);
    player_location_in = loc; opponent_data_in = opp; opponent_scored_in = osc;
    syncer_in_valid = 1'b1;
    if (ir_l) begin ir_in_valid = 1'b1; lunge_in = 1'b1; block_in = 1'b0; end
    @(negedge clk);
    syncer_in_valid = 1'b0; ir_in_valid = 1'b0; lunge_in = 1'b0;
    chk1({tag, " valid_early"}, data_out_valid, 1'b0);
    @(negedge clk);
    chk1({tag, " valid"}, data_out_valid, 1'b1);
    chk1({tag, " scored"}, player_scored_out, exp_sc);
    chk({tag, " player_data"}, player_data_out, exp_pd);
    chk({tag, " opp_data"}, opponent_data_out, opp);
    @(negedge clk);
    chk1({tag, " valid_after"}, data_out_valid, 1'b0);
    chk1({tag, " scored_after"}, player_scored_out, 1'b0);
    chk({tag, " player_hold"}, player_data_out, exp_pd);
  endtask

  logic [62:0] loc_a, loc_h;
  logic [88:0] opp_a, opp_h, opp_m, opp_hb;

  initial begin
    loc_a  = mk_loc(1825, 1018, 100, 200, 300, 400);
    loc_h  = mk_loc(4, 4, 100, 200, 300, 400);
    opp_a  = mk_data(0, mk_loc(0, 0, 33, 682, 1365, 341), 0, 0, 0);
    opp_h  = mk_data(0, mk_loc(0, 0, 31, 21, 0, 0), 0, 0, 0);
    opp_m  = mk_data(0, mk_loc(0, 0, 192, 256, 1365, 341), 0, 0, 0);
    opp_hb = mk_data(0, mk_loc(0, 0, 31, 21, 0, 0), 1, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst valid", data_out_valid, 1'b0);
    chk1("rst scored", player_scored_out, 1'b0);
    chk("rst player", player_data_out, '0);
    chk("rst opp", opponent_data_out, '0);
    rst_in = 1'b1;

    // IR alone never strobes the outputs
    ir_pulse(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk1("ir_only valid", data_out_valid, 1'b0);
      @(negedge clk);
    end

    sync_chk("idle_frame", loc_a, opp_a, 1'b0, 1'b0, 1'b0, mk_data(0, loc_a, 0, 0, 0));

    // Lunge hit, then hit latch blocks a second point
    set_loc(loc_h);
    ir_pulse(1'b0, 1'b1);
    sync_chk("lunge_hit", loc_h, opp_h, 1'b0, 1'b0, 1'b1, mk_data(1, loc_h, 2, 4, 4));
    sync_chk("lunge_latch", loc_h, opp_h, 1'b0, 1'b0, 1'b0, mk_data(1, loc_h, 2, 4, 4));

    // Fresh lunge misses, then the cleared latch allows a hit
    ir_pulse(1'b0, 1'b0);
    set_loc(loc_a);
    ir_pulse(1'b0, 1'b1);
    sync_chk("lunge_miss", loc_a, opp_m, 1'b0, 1'b0, 1'b0, mk_data(1, loc_a, 2, 1825, 1018));
    sync_chk("relunge_hit", loc_h, opp_h, 1'b0, 1'b0, 1'b1, mk_data(2, loc_h, 2, 1825, 1018));

    // Idle, two frames with no IR in between give identical records
    ir_pulse(1'b0, 1'b0);
    sync_chk("idle_a", loc_h, opp_a, 1'b0, 1'b0, 1'b0, mk_data(2, loc_h, 0, 1825, 1018));
    sync_chk("idle_b", loc_h, opp_a, 1'b0, 1'b0, 1'b0, mk_data(2, loc_h, 0, 1825, 1018));

    // Opponent blocking, then opponent scoring first
    ir_pulse(1'b0, 1'b1);
    sync_chk("opp_block", loc_h, opp_hb, 1'b0, 1'b0, 1'b0, mk_data(2, loc_h, 2, 4, 4));
    sync_chk("opp_scored", loc_h, opp_h, 1'b1, 1'b0, 1'b0, mk_data(2, loc_h, 0, 4, 4));

    // Block wins over lunge
    ir_pulse(1'b1, 1'b1);
    sync_chk("block_wins", loc_h, opp_h, 1'b0, 1'b0, 1'b0, mk_data(2, loc_h, 1, 4, 4));

    // IR with sync: frame judged as BLOCK, record shows the new LUNGE
    sync_chk("ir_with_sync", loc_h, opp_h, 1'b0, 1'b1, 1'b0, mk_data(2, loc_h, 2, 4, 4));
    sync_chk("after_ir_sync", loc_h, opp_h, 1'b0, 1'b0, 1'b1, mk_data(3, loc_h, 2, 4, 4));

    // Score saturates at 7
    for (int s = 4; s <= 8; s++) begin
      ir_pulse(1'b0, 1'b0);
      ir_pulse(1'b0, 1'b1);
      sync_chk($sformatf("sat%0d", s), loc_h, opp_h, 1'b0, 1'b0, 1'b1,
               mk_data((s > 7) ? 7 : s, loc_h, 2, 4, 4));
    end

    // Lunge expires after 30 frames
    ir_pulse(1'b0, 1'b0);
    ir_pulse(1'b0, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      sync_chk($sformatf("frames%0d", k), loc_h, opp_a, 1'b0, 1'b0, 1'b0,
               mk_data(7, loc_h, (k < 30) ? 2 : 0, 4, 4));
    end

    // Reset between sync and emit suppresses the strobe
    @(negedge clk);
    player_location_in = loc_h; opponent_data_in = opp_h; opponent_scored_in = 1'b0;
    syncer_in_valid = 1'b1;
    @(negedge clk);
    syncer_in_valid = 1'b0; rst_in = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk1("midrst valid", data_out_valid, 1'b0);
      chk1("midrst scored", player_scored_out, 1'b0);
      chk("midrst player", player_data_out, '0);
      chk("midrst opp", opponent_data_out, '0);
      @(negedge clk);
    end
    sync_chk("post_reset", loc_a, opp_a, 1'b0, 1'b0, 1'b0, mk_data(0, loc_a, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
